huff_decoder: RTL and testbench
===============================

# huff_decoder

Decodes the serial bitstream produced for a 3-symbol Huffman code back into 5-bit characters. Before decoding, the code table is loaded over the same 12-bit `io_in` bus, using the exact 9-bit word pair the encoder emits per symbol on `io_out[8:0]`: a character word, then a mask/value word. The block sits on the receive side of the tapeout harness, opposite `huff_encoder`.

## Interface
- `NSYM`, 3: table entries; fixed by the encoder word format.
- `MAXLEN`, 3: maximum code length in bits; equals the mask/value width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `io_in`  in  12  input bus:
  - [11] strobe; a word or bit is consumed only when this is 1.
  - [10] mode: 0 = table word, 1 = code bit.
  - [9] restart.
  - [8:0] table word in encoder format.
  - [0] code bit when mode = 1.
- `io_out`  out  12  output bus:
  - [4:0] decoded char.
  - [5] char_valid.
  - [6] error (sticky).
  - [7] table_ready.
  - [9:8] current shift length.
  - [11:10] entries loaded.

## Operation
- Word formats (bit 8, the encoder's done bit, is ignored):
  - Char word: [7:5] = 3'b011, [4:0] = char.
  - Code word: [7:6] = 2'b00, [5:3] = mask, [2:0] = value.
- FSM states: `S_LD_CHAR`, `S_LD_CODE`, `S_DECODE`.
- `S_LD_CHAR`:
  - Strobe with mode = 0 and a valid char word: latch `char[idx]`, go to `S_LD_CODE`.
  - Any other strobed word: set error, stay.
- `S_LD_CODE`:
  - Strobe with a valid code word: latch `mask[idx]` and `value[idx]`.
    - len = popcount(mask). mask must be 3'b001, 3'b011 or 3'b111; otherwise set error and mark the entry invalid.
    - idx++. If idx = 3, go to `S_DECODE` and set table_ready; otherwise go to `S_LD_CHAR`.
  - Malformed word: set error, stay.
- `S_DECODE`:
  - Strobe with mode = 1: `shreg <= {shreg[1:0], io_in[0]}`, `len <= len + 1`. The first received bit becomes the MSB of the code.
  - Match rule, evaluated on the updated shreg and length L: entry k matches if it is valid, its len == L, and `value[k] & mask[k] == shreg & mask[k]`.
  - First match in index order 0..2: drive char, pulse char_valid, clear shreg and len.
  - No match at L = 3: set error, clear shreg and len, emit no char.
  - Strobed words with mode = 0 in `S_DECODE` are ignored; error is not set.
- Restart: strobe with io_in[9] = 1, in any state, has priority over everything else.
  - Go to `S_LD_CHAR`.
  - Clear idx, all entry valid bits, shreg, len, error and table_ready.
- Error stays set until restart or reset.

## Timing
- Reset values (async, active-low):
  - FSM state `S_LD_CHAR`, all table entries invalid.
  - io_out = 12'h000.
- Inputs are sampled on the rising edge when strobe = 1. There is no backpressure: every cycle can accept one word or one bit.
- Decode latency: char and char_valid are registered in the same edge that samples the final code bit, and are visible the following cycle.
- char_valid is high for exactly one cycle. char holds its last value until the next match.
- table_ready goes high on the edge that accepts the third code word.
- io_out[11:10] counts 0..3 and saturates at 3.
- Reset asserted mid-load or mid-symbol: everything clears immediately, with no output pulse.
- Restart on the same edge as a completing bit: restart wins and no char is emitted.

## Structure
- Package `huff_pkg` holds:
  - Localparams for the word tags (3'b011, 2'b00) and `NSYM`/`MAXLEN`.
  - The FSM state enum.
  - A packed `huff_entry_t` with fields char[4:0], mask[2:0], value[2:0], len[1:0], valid.
- Sub-module `huff_code_match`: combinational. Inputs are the table, shreg and length. Outputs are hit and hit_char.
- FSM, table registers and shift register live in the `huff_decoder` top.

## Test plan
- Load the pairs below, then check table_ready = 1 and io_out[11:10] = 3:
  - (0x01, mask 001, value 000)
  - (0x02, mask 011, value 010)
  - (0x03, mask 011, value 011)
- Bits 0, 1,0, 1,1 → char_valid pulses 3 times, with chars 0x01, 0x02, 0x03, each one cycle after its final bit.
- Code word sent while in `S_LD_CHAR` → error = 1 and the load index is unchanged. Restart clears error.
- Table with no 3-bit codes (as above), bits 1,0,0 → 0x02 on bit 2. The next bit 0 decodes to 0x01 with no error.
- Table with code {mask 111, value 111} for 0x04 only → bits 1,1,0 raise error and clear len to 0.
- reset pulled low after 2 of 3 pairs are loaded → io_out = 0 asynchronously, and the load restarts from entry 0.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types and constants for the 3-symbol Huffman decoder.
// Word tags, table entry layout and the load/decode FSM states.
package huff_pkg;

  localparam int NSYM   = 3;
  localparam int MAXLEN = 3;

  localparam logic [2:0] TAG_CHAR = 3'b011;
  localparam logic [1:0] TAG_CODE = 2'b00;
  localparam logic [1:0] LAST_IDX = 2'(NSYM - 1);
  localparam logic [1:0] LEN_MAX  = 2'(MAXLEN);

  typedef enum logic [1:0] {
    S_LD_CHAR,
    S_LD_CODE,
    S_DECODE
  } state_t;

  typedef struct packed {
    logic [4:0] ch;
    logic [2:0] mask;
    logic [2:0] value;
    logic [1:0] len;
    logic       valid;
  } huff_entry_t;

  // Code length for a contiguous low-aligned mask; 0 flags an unusable mask.
  function automatic logic [1:0] mask_len(input logic [2:0] m);
    case (m)
      3'b001:  mask_len = 2'd1;
      3'b011:  mask_len = 2'd2;
      3'b111:  mask_len = 2'd3;
      default: mask_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational table lookup: first valid entry (index order) whose
// length and masked value agree with the shift register contents.
module huff_code_match
  import huff_pkg::*;
(
  input  huff_entry_t [NSYM-1:0] tbl_i,
  input  logic [2:0]             shreg_i,
  input  logic [1:0]             len_i,
  output logic                   hit_o,
  output logic [4:0]             hit_char_o
);

  always_comb begin
    logic found;
    found      = 1'b0;
    hit_char_o = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      if (!found && tbl_i[k].valid && (tbl_i[k].len == len_i) &&
          ((tbl_i[k].value & tbl_i[k].mask) == (shreg_i & tbl_i[k].mask))) begin
        found      = 1'b1;
        hit_char_o = tbl_i[k].ch;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman decoder: loads a 3-entry code table from encoder-format
// word pairs, then turns strobed code bits back into 5-bit characters.
module huff_decoder
  import huff_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  state_t                state_q;
  huff_entry_t [NSYM-1:0] tbl_q;
  logic [1:0]            idx_q;
  logic [2:0]            shreg_q, shreg_d;
  logic [1:0]            len_q, len_d;
  logic [4:0]            char_q;
  logic                  char_valid_q;
  logic                  error_q;
  logic                  ready_q;

  logic       strobe, mode, restart;
  logic       char_word_ok, code_word_ok;
  logic [1:0] code_len;
  logic       hit;
  logic [4:0] hit_char;
  logic       unused_done;

  assign strobe       = io_in[11];
  assign mode         = io_in[10];
  assign restart      = io_in[9];
  assign unused_done  = io_in[8];
  assign char_word_ok = !mode && (io_in[7:5] == TAG_CHAR);
  assign code_word_ok = !mode && (io_in[7:6] == TAG_CODE);
  assign code_len     = mask_len(io_in[5:3]);

  // The matcher sees the register contents as they would be after this bit.
  always_comb begin
    shreg_d = {shreg_q[1:0], io_in[0]};
    len_d   = len_q + 2'd1;
  end

  huff_code_match u_match (
    .tbl_i      (tbl_q),
    .shreg_i    (shreg_d),
    .len_i      (len_d),
    .hit_o      (hit),
    .hit_char_o (hit_char)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LD_CHAR;
      tbl_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      len_q        <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      error_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      char_valid_q <= 1'b0;
      if (strobe && restart) begin
        state_q <= S_LD_CHAR;
        idx_q   <= '0;
        shreg_q <= '0;
        len_q   <= '0;
        error_q <= 1'b0;
        ready_q <= 1'b0;
        for (int unsigned k = 0; k < NSYM; k++) tbl_q[k].valid <= 1'b0;
      end else if (strobe) begin
        case (state_q)
          S_LD_CHAR: begin
            if (char_word_ok) begin
              tbl_q[idx_q].ch <= io_in[4:0];
              state_q         <= S_LD_CODE;
            end else begin
              error_q <= 1'b1;
            end
          end
          S_LD_CODE: begin
            if (code_word_ok) begin
              tbl_q[idx_q].mask  <= io_in[5:3];
              tbl_q[idx_q].value <= io_in[2:0];
              tbl_q[idx_q].len   <= code_len;
              tbl_q[idx_q].valid <= (code_len != 2'd0);
              if (code_len == 2'd0) error_q <= 1'b1;
              idx_q <= idx_q + 2'd1;
              if (idx_q == LAST_IDX) begin
                state_q <= S_DECODE;
                ready_q <= 1'b1;
              end else begin
                state_q <= S_LD_CHAR;
              end
            end else begin
              error_q <= 1'b1;
            end
          end
          S_DECODE: begin
            if (mode) begin
              if (hit) begin
                char_q       <= hit_char;
                char_valid_q <= 1'b1;
                shreg_q      <= '0;
                len_q        <= '0;
              end else if (len_d == LEN_MAX) begin
                error_q <= 1'b1;
                shreg_q <= '0;
                len_q   <= '0;
              end else begin
                shreg_q <= shreg_d;
                len_q   <= len_d;
              end
            end
          end
          default: state_q <= S_LD_CHAR;
        endcase
      end
    end
  end

  assign io_out = {idx_q, len_q, ready_q, error_q, char_valid_q, char_q};

endmodule

// File: tb/tb_huff_decoder.sv
// Directed self-checking bench for huff_decoder.
module tb_huff_decoder;

  logic        clk;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int total = 0;
  int bad   = 0;

  huff_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] chr_w(input logic [4:0] c);
    return {3'b100, 1'b0, 3'b011, c};
  endfunction

  function automatic logic [11:0] code_w(input logic [2:0] m, input logic [2:0] v);
    return {3'b100, 1'b0, 2'b00, m, v};
  endfunction

  function automatic logic [11:0] bit_w(input logic b);
    return {3'b110, 8'h00, b};
  endfunction

  localparam logic [11:0] RESTART_W = 12'hA00;

  // Drive one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic put(input logic [11:0] w);
    io_in = w;
    @(posedge clk);
    #1;
    io_in = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table_a();
    put(chr_w(5'h01)); put(code_w(3'b001, 3'b000));
    put(chr_w(5'h02)); put(code_w(3'b011, 3'b010));
    put(chr_w(5'h03)); put(code_w(3'b011, 3'b011));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_in = '0;
    #3;
    total++;
    if (io_out !== 12'h000) begin
      bad++; $display("FAIL reset_out got=%h want=%h", io_out, 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_load();
    put(chr_w(5'h01));
    put(code_w(3'b001, 3'b000));
    total++;
    if (io_out[11:10] !== 2'd1 || io_out[7] !== 1'b0) begin
      bad++; $display("FAIL load_pair1 got=%h want cnt=1 ready=0", io_out);
    end
    put(chr_w(5'h02)); put(code_w(3'b011, 3'b010));
    put(chr_w(5'h03)); put(code_w(3'b011, 3'b011));
    total++;
    if (io_out !== 12'hC80) begin
      bad++; $display("FAIL load_ready got=%h want=%h", io_out, 12'hC80);
    end
  endtask

  task automatic test_decode();
    put(bit_w(1'b0));
    total++;
    if (io_out[5] !== 1'b1 || io_out[4:0] !== 5'h01) begin
      bad++; $display("FAIL dec_sym0 got=%h want valid=1 char=01", io_out);
    end
    put(bit_w(1'b1));
    total++;
    if (io_out[5] !== 1'b0 || io_out[9:8] !== 2'd1 || io_out[4:0] !== 5'h01) begin
      bad++; $display("FAIL dec_partial got=%h want valid=0 len=1 char=01", io_out);
    end
    put(bit_w(1'b0));
    total++;
    if (io_out[5] !== 1'b1 || io_out[4:0] !== 5'h02 || io_out[9:8] !== 2'd0) begin
      bad++; $display("FAIL dec_sym1 got=%h want valid=1 char=02 len=0", io_out);
    end
    put(bit_w(1'b1));
    put(bit_w(1'b1));
    total++;
    if (io_out[5] !== 1'b1 || io_out[4:0] !== 5'h03) begin
      bad++; $display("FAIL dec_sym2 got=%h want valid=1 char=03", io_out);
    end
    idle();
    total++;
    if (io_out !== 12'hC83) begin
      bad++; $display("FAIL dec_hold got=%h want=%h", io_out, 12'hC83);
    end
    put(chr_w(5'h1F));
    total++;
    if (io_out !== 12'hC83) begin
      bad++; $display("FAIL dec_ignore_word got=%h want=%h", io_out, 12'hC83);
    end
  endtask

  task automatic test_load_error();
    put(RESTART_W);
    put(code_w(3'b001, 3'b000));
    total++;
    if (io_out[6] !== 1'b1 || io_out[11:10] !== 2'd0 || io_out[7] !== 1'b0) begin
      bad++; $display("FAIL lderr_set got=%h want err=1 cnt=0", io_out);
    end
    put(chr_w(5'h01));
    put(code_w(3'b001, 3'b000));
    total++;
    if (io_out[6] !== 1'b1 || io_out[11:10] !== 2'd1) begin
      bad++; $display("FAIL lderr_sticky got=%h want err=1 cnt=1", io_out);
    end
    put(RESTART_W);
    total++;
    if (io_out[11:5] !== 7'd0) begin
      bad++; $display("FAIL lderr_clear got=%h want upper=0", io_out);
    end
  endtask

  task automatic test_no3bit();
    put(RESTART_W);
    load_table_a();
    put(bit_w(1'b1));
    put(bit_w(1'b0));
    total++;
    if (io_out[5] !== 1'b1 || io_out[4:0] !== 5'h02) begin
      bad++; $display("FAIL no3_sym02 got=%h want valid=1 char=02", io_out);
    end
    put(bit_w(1'b0));
    total++;
    if (io_out !== 12'hCA1) begin
      bad++; $display("FAIL no3_sym01 got=%h want=%h", io_out, 12'hCA1);
    end
  endtask

  task automatic test_restart_wins();
    put(bit_w(1'b1));
    put(12'hE00);
    total++;
    if (io_out[11:5] !== 7'd0) begin
      bad++; $display("FAIL restart_wins got=%h want upper=0", io_out);
    end
  endtask

  task automatic test_nomatch();
    put(RESTART_W);
    put(chr_w(5'h04)); put(code_w(3'b111, 3'b111));
    put(chr_w(5'h05)); put(code_w(3'b011, 3'b001));
    put(chr_w(5'h06)); put(code_w(3'b111, 3'b000));
    total++;
    if (io_out[11:5] !== 7'b11_00_1_0_0) begin
      bad++; $display("FAIL nm_load got=%h want cnt=3 ready=1 err=0", io_out);
    end
    put(bit_w(1'b1));
    put(bit_w(1'b1));
    total++;
    if (io_out[9:8] !== 2'd2 || io_out[6] !== 1'b0) begin
      bad++; $display("FAIL nm_len2 got=%h want len=2 err=0", io_out);
    end
    put(bit_w(1'b0));
    total++;
    if (io_out[6] !== 1'b1 || io_out[9:8] !== 2'd0 || io_out[5] !== 1'b0) begin
      bad++; $display("FAIL nm_error got=%h want err=1 len=0 valid=0", io_out);
    end
  endtask

  task automatic test_async_reset();
    put(RESTART_W);
    put(chr_w(5'h01)); put(code_w(3'b001, 3'b000));
    put(chr_w(5'h02)); put(code_w(3'b011, 3'b010));
    total++;
    if (io_out[11:10] !== 2'd2) begin
      bad++; $display("FAIL ar_two got=%h want cnt=2", io_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (io_out !== 12'h000) begin
      bad++; $display("FAIL ar_async got=%h want=%h", io_out, 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
    load_table_a();
    total++;
    if (io_out !== 12'hC80) begin
      bad++; $display("FAIL ar_reload got=%h want=%h", io_out, 12'hC80);
    end
    put(bit_w(1'b0));
    total++;
    if (io_out !== 12'hCA1) begin
      bad++; $display("FAIL ar_decode got=%h want=%h", io_out, 12'hCA1);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_decode();
    test_load_error();
    test_no3bit();
    test_restart_wins();
    test_nomatch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
